// File: rtl/tl_bypass_seq_pkg.sv
// Shared types and default constants for the bypass-select sequencer.
package tl_bypass_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2,
        RESP   = 2'd3
    } seq_state_t;

    localparam int unsigned DEFAULT_CNT_W          = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/tl_bypass_sequencer_counter.sv
// Outstanding A->D transaction counter with a sticky protocol error flag.
// A D with nothing outstanding leaves the count at zero and flags the error.
module tl_inflight_counter
    import tl_bypass_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a_fire,
    input  logic             d_fire,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             protocol_err
);

    // Up/down count of transactions awaiting their D response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count        <= '0;
            protocol_err <= 1'b0;
        end else if (a_fire && !d_fire) begin
            count <= count + CNT_W'(1);
        end else if (d_fire && !a_fire) begin
            if (count == '0) begin
                protocol_err <= 1'b1;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign full = &count;

endmodule

// File: rtl/tl_bypass_sequencer.sv
// Bypass-select switch sequencer: blocks new A requests, drains outstanding
// transactions, then flips the registered bypass select and acknowledges.
// Optional drain timeout is enabled by defining TL_BYPASS_SEQ_TIMEOUT_EN.
module tl_bypass_sequencer
    import tl_bypass_seq_pkg::*;
#(
    parameter int unsigned CNT_W          = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter bit          RESET_BYPASS   = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_bypass,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_timeout,
    output logic             resp_bypass,
    input  logic             in_a_valid,
    output logic             in_a_ready,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    input  logic             d_valid,
    input  logic             d_ready,
    output logic             bypass,
    output logic [CNT_W-1:0] inflight,
    output logic             protocol_err
);

    seq_state_t state, next_state;
    logic       target;
    logic       gate;
    logic       full;
    logic       a_fire;
    logic       d_fire;
    logic       timeout_hit;

    assign a_fire = out_a_valid & out_a_ready;
    assign d_fire = d_valid & d_ready;

    tl_inflight_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clock        (clock),
        .reset        (reset),
        .a_fire       (a_fire),
        .d_fire       (d_fire),
        .count        (inflight),
        .full         (full),
        .protocol_err (protocol_err)
    );

`ifdef TL_BYPASS_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] drain_cycles;
    logic            resp_timeout_q;

    assign timeout_hit  = (drain_cycles == TO_W'(TIMEOUT_CYCLES - 1));
    assign resp_timeout = resp_timeout_q;

    // Count cycles spent in DRAIN; cleared whenever DRAIN is entered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drain_cycles <= '0;
        end else if (state != DRAIN) begin
            drain_cycles <= '0;
        end else if (!timeout_hit) begin
            drain_cycles <= drain_cycles + TO_W'(1);
        end
    end

    // Capture whether RESP was reached by abandoning the drain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_timeout_q <= 1'b0;
        end else if (next_state == RESP && state != RESP) begin
            resp_timeout_q <= (state == DRAIN);
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign resp_timeout       = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (req_valid) next_state = (req_bypass == bypass) ? RESP : DRAIN;
            DRAIN: begin
                if (inflight == '0) begin
                    next_state = SWITCH;
                end else if (timeout_hit) begin
                    next_state = RESP;
                end
            end
            SWITCH: next_state = RESP;
            RESP:   if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake and gating outputs decoded from state
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        gate       = (state != IDLE) || full;
    end

    assign out_a_valid = in_a_valid & ~gate;
    assign in_a_ready  = out_a_ready & ~gate;

    // Requested target and the bypass select itself
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            target <= RESET_BYPASS;
            bypass <= RESET_BYPASS;
        end else begin
            if (state == IDLE && req_valid) begin
                target <= req_bypass;
            end
            if (state == DRAIN && next_state == SWITCH) begin
                bypass <= target;
            end
        end
    end

    // bypass is stable throughout RESP, so it doubles as the reported value
    assign resp_bypass = bypass;

endmodule

// File: tb/tb_tl_bypass_sequencer.sv
// Self-checking bench for tl_bypass_sequencer (CNT_W=2, TIMEOUT_CYCLES=16).
module tb_tl_bypass_sequencer;

    localparam int unsigned CNT_W   = 2;
    localparam int          MAX_CNT = (1 << CNT_W) - 1;
    localparam int          TO_CYC  = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0, req_bypass = 1'b0, resp_ready = 1'b0;
    logic             in_a_valid = 1'b0, out_a_ready = 1'b0;
    logic             d_valid = 1'b0, d_ready = 1'b0;
    logic             req_ready, resp_valid, resp_timeout, resp_bypass;
    logic             in_a_ready, out_a_valid, bypass, protocol_err;
    logic [CNT_W-1:0] inflight;

    always #5 clock = ~clock;

    tl_bypass_sequencer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TO_CYC),
        .RESET_BYPASS   (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_bypass   (req_bypass),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_timeout (resp_timeout),
        .resp_bypass  (resp_bypass),
        .in_a_valid   (in_a_valid),
        .in_a_ready   (in_a_ready),
        .out_a_valid  (out_a_valid),
        .out_a_ready  (out_a_ready),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .bypass       (bypass),
        .inflight     (inflight),
        .protocol_err (protocol_err)
    );

    typedef struct {
        logic byp;
        logic to;
    } resp_t;

    resp_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Reference model: transaction-level view of the link and switch request
    int   m_cnt;
    bit   m_perr, m_byp, m_busy, m_resp, m_target;
    bit   m_drain, m_settle;
    int   m_dcyc;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_perr = 0; m_byp = 1'b1; m_busy = 0; m_resp = 0;
        m_target = 1'b1; m_drain = 0; m_settle = 0; m_dcyc = 0;
        exp_q.delete();
    endtask

    function automatic resp_t mk(input logic byp, input logic to);
        resp_t r;
        r.byp = byp;
        r.to  = to;
        return r;
    endfunction

    // One clock cycle: check registered outputs, drive inputs, check gating, advance model
    task automatic step(input logic rv, input logic rb, input logic av, input logic ar,
                        input logic dv, input logic dr, input logic rr);
        bit gate_e, a_f, d_f;
        int n_cnt;
        bit n_perr, n_byp, n_busy, n_resp, n_drain, n_settle;
        int n_dcyc;
        @(negedge clock);
        check("inflight", int'(inflight), m_cnt);
        check("bypass", int'(bypass), int'(m_byp));
        check("protocol_err", int'(protocol_err), int'(m_perr));
        check("resp_valid", int'(resp_valid), int'(m_resp));
        req_valid = rv; req_bypass = rb; in_a_valid = av; out_a_ready = ar;
        d_valid = dv; d_ready = dr; resp_ready = rr;
        #1;
        gate_e = m_busy || (m_cnt == MAX_CNT);
        check("in_a_ready", int'(in_a_ready), int'(ar && !gate_e));
        check("out_a_valid", int'(out_a_valid), int'(av && !gate_e));
        check("req_ready", int'(req_ready), int'(!m_busy));

        a_f = av && ar && !gate_e;
        d_f = dv && dr;
        n_cnt = m_cnt; n_perr = m_perr; n_byp = m_byp; n_busy = m_busy;
        n_resp = m_resp; n_drain = m_drain; n_settle = m_settle; n_dcyc = m_dcyc;
        if (a_f && !d_f) n_cnt = m_cnt + 1;
        else if (d_f && !a_f) begin
            if (m_cnt == 0) n_perr = 1;
            else n_cnt = m_cnt - 1;
        end
        if (m_resp && rr) begin
            n_resp = 0;
            n_busy = 0;
        end
        if (!m_busy && rv) begin
            n_busy = 1;
            if (rb == m_byp) begin
                n_resp = 1;
                exp_q.push_back(mk(rb, 1'b0));
            end else begin
                n_drain  = 1;
                n_dcyc   = 0;
                m_target = rb;
            end
        end
        if (m_drain) begin
            if (m_cnt == 0) begin
                n_drain  = 0;
                n_byp    = m_target;
                n_settle = 1;
            end
`ifdef TL_BYPASS_SEQ_TIMEOUT_EN
            else if (m_dcyc == TO_CYC - 1) begin
                n_drain = 0;
                n_resp  = 1;
                exp_q.push_back(mk(m_byp, 1'b1));
            end else begin
                n_dcyc = m_dcyc + 1;
            end
`endif
        end
        if (m_settle) begin
            n_settle = 0;
            n_resp   = 1;
            exp_q.push_back(mk(m_byp, 1'b0));
        end
        m_cnt = n_cnt; m_perr = n_perr; m_byp = n_byp; m_busy = n_busy;
        m_resp = n_resp; m_drain = n_drain; m_settle = n_settle; m_dcyc = n_dcyc;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        req_valid = 0; d_valid = 0; d_ready = 0; resp_ready = 0;
        in_a_valid = 1; out_a_ready = 1;
        #1;
        check("rst_bypass", int'(bypass), 1);
        check("rst_inflight", int'(inflight), 0);
        check("rst_perr", int'(protocol_err), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_in_a_ready", int'(in_a_ready), 1);
        check("rst_resp_bypass", int'(resp_bypass), 1);
        model_reset();
        @(negedge clock);
        in_a_valid = 0;
        reset = 1'b0;
    endtask

    // Scoreboard monitor: compares each response handshake against the queue
    always @(negedge clock) begin
        resp_t e;
        #2;
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL resp_unexpected: got response bypass=%0d with none expected at %0t",
                         resp_bypass, $time);
            end else begin
                e = exp_q.pop_front();
                check("resp_bypass", int'(resp_bypass), int'(e.byp));
                check("resp_timeout", int'(resp_timeout), int'(e.to));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Switch to 0 with nothing outstanding
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 1);

        // Three outstanding A, a blocked fourth, switch request, spaced D responses
        repeat (3) step(0, 0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 1, 0, 0, 1);
        step(1, 1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            step(0, 0, 1, 1, (i == 2 || i == 4 || i == 6), 1, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 1);

        // Simultaneous A and D at count 2
        repeat (2) step(0, 0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 1, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                 (m_cnt > 0) && ($urandom_range(0, 2) == 0), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1));

        // Drain everything outstanding
        for (int i = 0; i < 30; i++) step(0, 0, 0, 0, m_cnt > 0, 1, 1);
        check("sb_empty_after_random", exp_q.size(), 0);

        // D with nothing outstanding
        step(0, 0, 0, 0, 1, 1, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 1);

        // One A never answered, then a switch request
        step(0, 0, 1, 1, 0, 0, 1);
        step(1, !m_byp, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2 * TO_CYC + 8; i++) step(0, 0, 1, 1, 0, 0, 1);

        apply_reset();
        repeat (3) step(0, 0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, m_cnt > 0, 1, 1);
        check("sb_empty_final", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tl_bypass_sequencer.md
# tl_bypass_sequencer

Sequences switching of the bus bypass select that steers TileLink-UL traffic between the real downstream port and the error device. The block sits on the upstream A/D link in front of the bypass crossbar. It accepts a software switch request, stops new A requests, and waits until every outstanding transaction has received its D response. Only then does it flip the registered bypass select and acknowledge the request, so that no in-flight request is ever split across the two targets.

## Interface
Parameters:
- CNT_W, 4: width of the in-flight counter; maximum outstanding count is 2^CNT_W-1.
- TIMEOUT_CYCLES, 1024: number of DRAIN cycles before the request is abandon­ed (used only with the timeout feature).
- RESET_BYPASS, 1: value of the bypass select after reset. 1 routes traffic to the error device.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  switch request valid.
- req_ready  out  1  request accepted when high together with req_valid.
- req_bypass  in  1  requested target bypass value.
- resp_valid  out  1  request completed.
- resp_ready  in  1  response consumed.
- resp_timeout  out  1  drain timed out; the bypass select is unchanged.
- resp_bypass  out  1  bypass value in effect at the time of the response.
- in_a_valid  in  1  upstream A valid.
- in_a_ready  out  1  upstream A ready (gated).
- out_a_valid  out  1  A valid toward the crossbar (gated).
- out_a_ready  in  1  A ready from the crossbar.
- d_valid  in  1  D valid on the upstream link.
- d_ready  in  1  D ready on the upstream link.
- bypass  out  1  registered bypass select driven to the crossbar.
- inflight  out  CNT_W  current outstanding count.
- protocol_err  out  1  sticky flag: a D fired while the count was 0.

## Operation
- Gate signal: gate = (state != IDLE) or (inflight == all-ones).
- A path: out_a_valid = in_a_valid & ~gate; in_a_ready = out_a_ready & ~gate.
- a_fire = out_a_valid & out_a_ready; d_fire = d_valid & d_ready. Each A produces exactly one D (single beat).
- Counter update:
  - a_fire only: +1.
  - d_fire only: -1.
  - both in the same cycle: count unchanged.
  - d_fire only while the count is 0: count stays 0 and protocol_err sets.
  - The counter cannot overflow because the gate blocks A at all-ones.
- FSM states: IDLE, DRAIN, SWITCH, RESP.
  - IDLE: req_ready = 1. On acceptance, if req_bypass == bypass go to RESP (no-op switch); otherwise latch the target and go to DRAIN.
  - DRAIN: when inflight == 0, load bypass <= target and go to SWITCH.
  - SWITCH: one settle cycle, then RESP.
  - RESP: resp_valid = 1. Hold resp_timeout and resp_bypass stable until resp_ready, then go to IDLE.
- An A that fires in the same cycle as request acceptance is counted and drained.
- Reset values: state IDLE, bypass = RESET_BYPASS, inflight 0, protocol_err 0, resp_valid 0, resp_timeout 0, resp_bypass = RESET_BYPASS, req_ready 1.
- Reset asserted mid-operation: everything returns to the reset values immediately. Any pending request is lost.

## Timing
- Request accepted at cycle 0 with count 0:
  - DRAIN in cycle 1.
  - New bypass visible in cycle 2 (SWITCH).
  - resp_valid in cycle 3.
- No-op request: resp_valid in cycle 1.
- Drain extends the sequence one cycle per cycle that the count stays non-zero.
- Gating takes effect in cycle 1 and is released in the cycle after the response handshake (back in IDLE).
- Every output is registered except in_a_ready, out_a_valid and req_ready, which are combinational from state and the handshake inputs.

## Configuration
- TL_BYPASS_SEQ_TIMEOUT_EN defined:
  - A cycle counter runs in DRAIN and clears on entry to DRAIN.
  - When it reaches TIMEOUT_CYCLES with the count still non-zero, go to RESP with resp_timeout = 1 and bypass unchanged.
  - The count keeps tracking after the timeout.
- TL_BYPASS_SEQ_TIMEOUT_EN undefined:
  - DRAIN waits indefinitely.
  - resp_timeout is tied to 0.
  - No timeout counter is built.

## Structure
- Package tl_bypass_seq_pkg holds:
  - the state enum (IDLE, DRAIN, SWITCH, RESP);
  - the default CNT_W and TIMEOUT_CYCLES constants.
- Sub-module tl_inflight_counter holds:
  - the up/down counter, saturating at 0;
  - the protocol_err flag;
  - the full indication.
- The FSM and gating logic live in the top module.

## Test plan
- Reset, idle, req_bypass=0 accepted at cycle 0 → bypass=0 in cycle 2, resp_valid=1 in cycle 3, resp_bypass=0, resp_timeout=0.
- 3 A fired, then switch request → in_a_ready=0 from the next cycle. D responses at cycles 5, 7 and 9 → bypass changes only after the third D. No A passes while gated.
- Simultaneous a_fire and d_fire at count 2 → count stays 2. A d_fire at count 0 → count 0, protocol_err=1 until reset.
- CNT_W=2 with 3 A in flight → in_a_ready=0 even in IDLE. One D → A is accepted again.
- TL_BYPASS_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=16 and a D that never returns → RESP with resp_timeout=1 and bypass unchanged. Without the macro → the block stays in DRAIN.
- Reset asserted in DRAIN → bypass=RESET_BYPASS, inflight 0, state IDLE, gate released.
